// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- pipeline hazard controller for the 5-stage core.
//
// Sequences the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline
// registers around four events. It handles the hazards that forwarding
// cannot resolve:
//   - load-use: a one-cycle stall, with a bubble injected into ID/EX;
//   - taken branch: IF/ID and ID/EX are flushed;
//   - multi-cycle data-memory access: the front of the pipe is frozen and
//     bubbles are fed into MEM/WB;
//   - halt: everything is frozen until reset.
//
// Optional build macro: HAZ_PERF_EN. It adds saturating stall and flush
// performance counters.
//
// Ports:
//   clk, rst_n         core clock; synchronous active-low reset.
//                      All outputs are forced to 0 while rst_n is low.
//   if_id_rs/rt        source registers of the instruction in ID.
//   if_id_use_rs/rt    the ID instruction actually reads rs/rt.
//   id_ex_rd           destination register of the instruction in EX.
//   id_ex_memrd        the EX instruction is a load.
//   branch_taken       EX resolved a taken branch/jump this cycle.
//   ex_mem_memop       the MEM instruction accesses data memory.
//   dmem_rdy           data memory completes its access this cycle.
//   mem_wb_halt        a halt instruction is in WB.
//   stall_*            hold the PC or the named pipeline register.
//   bubble_id_ex       load a NOP into ID/EX.
//   bubble_mem_wb      load a NOP into MEM/WB.
//   flush_if_id        clear IF/ID to a NOP.
//   flush_id_ex        clear ID/EX to a NOP.
//   halted             the core is halted.
//   perf_stall_cnt     (HAZ_PERF_EN only) cycles with stall_pc high,
//                      not counting cycles spent in HALT.
//   perf_flush_cnt     (HAZ_PERF_EN only) cycles with flush_if_id high.
module hazard_ctrl #(
  parameter int REG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] if_id_rs,
  input  logic [REG_W-1:0] if_id_rt,
  input  logic             if_id_use_rs,
  input  logic             if_id_use_rt,
  input  logic [REG_W-1:0] id_ex_rd,
  input  logic             id_ex_memrd,
  input  logic             branch_taken,
  input  logic             ex_mem_memop,
  input  logic             dmem_rdy,
  input  logic             mem_wb_halt,
  output logic             stall_pc,
  output logic             stall_if_id,
  output logic             stall_id_ex,
  output logic             stall_ex_mem,
  output logic             bubble_id_ex,
  output logic             bubble_mem_wb,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             halted
`ifdef HAZ_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_stall_cnt,
  output logic [CNT_W-1:0] perf_flush_cnt
`endif
);

  typedef enum logic [1:0] {
    S_RUN,
    S_MEMWAIT,
    S_HALT
  } state_t;

  state_t state_q, state_d;
  logic   pend_flush_q, pend_flush_d;
  logic   memwait;
  logic   lduse;

  always_comb begin
    memwait = ex_mem_memop & ~dmem_rdy;
    lduse   = id_ex_memrd & (id_ex_rd != '0) &
              ((if_id_use_rs & (id_ex_rd == if_id_rs)) |
               (if_id_use_rt & (id_ex_rd == if_id_rt)));
  end

  always_comb begin
    state_d       = state_q;
    pend_flush_d  = pend_flush_q;
    stall_pc      = 1'b0;
    stall_if_id   = 1'b0;
    stall_id_ex   = 1'b0;
    stall_ex_mem  = 1'b0;
    bubble_id_ex  = 1'b0;
    bubble_mem_wb = 1'b0;
    flush_if_id   = 1'b0;
    flush_id_ex   = 1'b0;
    halted        = 1'b0;

    case (state_q)
      S_HALT: begin
        halted       = 1'b1;
        stall_pc     = 1'b1;
        stall_if_id  = 1'b1;
        stall_id_ex  = 1'b1;
        stall_ex_mem = 1'b1;
      end
      default: begin
        // RUN and MEMWAIT share one decision tree. A MEMWAIT cycle with
        // dmem_rdy=1 is the release cycle and behaves exactly like a RUN
        // cycle without memwait, which is also where a deferred flush
        // finally takes effect.
        if (memwait) begin
          stall_pc      = 1'b1;
          stall_if_id   = 1'b1;
          stall_id_ex   = 1'b1;
          stall_ex_mem  = 1'b1;
          bubble_mem_wb = 1'b1;
          state_d       = S_MEMWAIT;
          // The branch is held in EX, so its flush has to wait for release.
          pend_flush_d  = pend_flush_q | branch_taken;
        end else begin
          state_d      = S_RUN;
          pend_flush_d = 1'b0;
          if (pend_flush_q | branch_taken) begin
            // The flush also discards the ID instruction, so any load-use
            // hazard it had no longer matters.
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
          end else if (lduse) begin
            stall_pc     = 1'b1;
            stall_if_id  = 1'b1;
            bubble_id_ex = 1'b1;
          end
        end
        if (mem_wb_halt) begin
          state_d = S_HALT;
        end
      end
    endcase

    if (!rst_n) begin
      stall_pc      = 1'b0;
      stall_if_id   = 1'b0;
      stall_id_ex   = 1'b0;
      stall_ex_mem  = 1'b0;
      bubble_id_ex  = 1'b0;
      bubble_mem_wb = 1'b0;
      flush_if_id   = 1'b0;
      flush_id_ex   = 1'b0;
      halted        = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_RUN;
      pend_flush_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_flush_q <= pend_flush_d;
    end
  end

`ifdef HAZ_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Both counters saturate at all-ones instead of wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_pc && (state_q != S_HALT) && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (flush_if_id && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`else
  // Without the counters, the controller state alone defines behaviour.
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl -- directed self-checking bench for hazard_ctrl.
//
// Inputs are driven 1 time unit after a rising edge. The combinational
// outputs are sampled at the following falling edge.
//
// Output vector bit order, MSB first:
//   stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, bubble_id_ex,
//   bubble_mem_wb, flush_if_id, flush_id_ex, halted
module tb_hazard_ctrl;

  localparam logic [8:0] O_NONE  = 9'b000000000;
  localparam logic [8:0] O_LDUSE = 9'b110010000;
  localparam logic [8:0] O_WAIT  = 9'b111101000;
  localparam logic [8:0] O_FLUSH = 9'b000000110;
  localparam logic [8:0] O_HALT  = 9'b111100001;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] if_id_rs, if_id_rt, id_ex_rd;
  logic       if_id_use_rs, if_id_use_rt, id_ex_memrd;
  logic       branch_taken, ex_mem_memop, dmem_rdy, mem_wb_halt;
  logic       stall_pc, stall_if_id, stall_id_ex, stall_ex_mem;
  logic       bubble_id_ex, bubble_mem_wb, flush_if_id, flush_id_ex, halted;
  logic [8:0] outs;
`ifdef HAZ_PERF_EN
  logic [15:0] perf_stall_cnt, perf_flush_cnt;
`endif

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign outs = {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, bubble_id_ex,
                 bubble_mem_wb, flush_if_id, flush_id_ex, halted};

  hazard_ctrl #(.REG_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
    .if_id_use_rs(if_id_use_rs), .if_id_use_rt(if_id_use_rt),
    .id_ex_rd(id_ex_rd), .id_ex_memrd(id_ex_memrd),
    .branch_taken(branch_taken), .ex_mem_memop(ex_mem_memop),
    .dmem_rdy(dmem_rdy), .mem_wb_halt(mem_wb_halt),
    .stall_pc(stall_pc), .stall_if_id(stall_if_id),
    .stall_id_ex(stall_id_ex), .stall_ex_mem(stall_ex_mem),
    .bubble_id_ex(bubble_id_ex), .bubble_mem_wb(bubble_mem_wb),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .halted(halted)
`ifdef HAZ_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_id_rs     = 4'd0;
    if_id_rt     = 4'd0;
    if_id_use_rs = 1'b0;
    if_id_use_rt = 1'b0;
    id_ex_rd     = 4'd0;
    id_ex_memrd  = 1'b0;
    branch_taken = 1'b0;
    ex_mem_memop = 1'b0;
    dmem_rdy     = 1'b1;
    mem_wb_halt  = 1'b0;
  endtask

  task automatic set_lduse();
    id_ex_memrd  = 1'b1;
    id_ex_rd     = 4'd5;
    if_id_rs     = 4'd5;
    if_id_use_rs = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    set_lduse();
    branch_taken = 1'b1;
    tick();
    tick();
    @(negedge clk);
    n_run++;
    if (outs !== O_NONE) begin
      n_fail++;
      $display("FAIL reset_outs got %b expected %b", outs, O_NONE);
    end else $display("[TB] reset_outs ok %b", outs);
    tick();
    rst_n = 1'b1;
    idle_inputs();
    @(negedge clk);
    n_run++;
    if (outs !== O_NONE) begin
      n_fail++;
      $display("FAIL reset_idle got %b expected %b", outs, O_NONE);
    end else $display("[TB] reset_idle ok %b", outs);
    tick();
  endtask

  task automatic test_load_use();
    set_lduse();
    @(negedge clk);
    n_run++;
    if (outs !== O_LDUSE) begin
      n_fail++;
      $display("FAIL lduse_rs got %b expected %b", outs, O_LDUSE);
    end else $display("[TB] lduse_rs ok %b", outs);
    tick();
    id_ex_memrd = 1'b0;
    @(negedge clk);
    n_run++;
    if (outs !== O_NONE) begin
      n_fail++;
      $display("FAIL lduse_after got %b expected %b", outs, O_NONE);
    end else $display("[TB] lduse_after ok %b", outs);
    tick();
    // rt-side match, rs compares a different register
    idle_inputs();
    id_ex_memrd  = 1'b1;
    id_ex_rd     = 4'd9;
    if_id_rs     = 4'd3;
    if_id_use_rs = 1'b1;
    if_id_rt     = 4'd9;
    if_id_use_rt = 1'b1;
    @(negedge clk);
    n_run++;
    if (outs !== O_LDUSE) begin
      n_fail++;
      $display("FAIL lduse_rt got %b expected %b", outs, O_LDUSE);
    end else $display("[TB] lduse_rt ok %b", outs);
    tick();
    // the register matches but is not actually read
    if_id_use_rt = 1'b0;
    @(negedge clk);
    n_run++;
    if (outs !== O_NONE) begin
      n_fail++;
      $display("FAIL lduse_unused got %b expected %b", outs, O_NONE);
    end else $display("[TB] lduse_unused ok %b", outs);
    tick();
    // a non-load to the same register must not stall
    id_ex_memrd  = 1'b0;
    if_id_use_rt = 1'b1;
    @(negedge clk);
    n_run++;
    if (outs !== O_NONE) begin
      n_fail++;
      $display("FAIL lduse_noload got %b expected %b", outs, O_NONE);
    end else $display("[TB] lduse_noload ok %b", outs);
    tick();
    idle_inputs();
  endtask

  task automatic test_r0();
    id_ex_memrd  = 1'b1;
    id_ex_rd     = 4'd0;
    if_id_rs     = 4'd0;
    if_id_use_rs = 1'b1;
    if_id_rt     = 4'd0;
    if_id_use_rt = 1'b1;
    @(negedge clk);
    n_run++;
    if (outs !== O_NONE) begin
      n_fail++;
      $display("FAIL r0_nohazard got %b expected %b", outs, O_NONE);
    end else $display("[TB] r0_nohazard ok %b", outs);
    tick();
    idle_inputs();
  endtask

  task automatic test_memwait();
    ex_mem_memop = 1'b1;
    dmem_rdy     = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_run++;
      if (outs !== O_WAIT) begin
        n_fail++;
        $display("FAIL memwait_c%0d got %b expected %b", i, outs, O_WAIT);
      end else $display("[TB] memwait_c%0d ok %b", i, outs);
      tick();
    end
    dmem_rdy = 1'b1;
    @(negedge clk);
    n_run++;
    if (outs !== O_NONE) begin
      n_fail++;
      $display("FAIL memwait_release got %b expected %b", outs, O_NONE);
    end else $display("[TB] memwait_release ok %b", outs);
    tick();
    // back in RUN: a plain load-use must be handled normally
    ex_mem_memop = 1'b0;
    set_lduse();
    @(negedge clk);
    n_run++;
    if (outs !== O_LDUSE) begin
      n_fail++;
      $display("FAIL memwait_run got %b expected %b", outs, O_LDUSE);
    end else $display("[TB] memwait_run ok %b", outs);
    tick();
    idle_inputs();
  endtask

  task automatic test_deferred_flush();
    ex_mem_memop = 1'b1;
    dmem_rdy     = 1'b0;
    branch_taken = 1'b1;
    @(negedge clk);
    n_run++;
    if (outs !== O_WAIT) begin
      n_fail++;
      $display("FAIL dflush_c0 got %b expected %b", outs, O_WAIT);
    end else $display("[TB] dflush_c0 ok %b", outs);
    tick();
    branch_taken = 1'b0;
    @(negedge clk);
    n_run++;
    if (outs !== O_WAIT) begin
      n_fail++;
      $display("FAIL dflush_c1 got %b expected %b", outs, O_WAIT);
    end else $display("[TB] dflush_c1 ok %b", outs);
    tick();
    dmem_rdy = 1'b1;
    @(negedge clk);
    n_run++;
    if (outs !== O_FLUSH) begin
      n_fail++;
      $display("FAIL dflush_release got %b expected %b", outs, O_FLUSH);
    end else $display("[TB] dflush_release ok %b", outs);
    tick();
    ex_mem_memop = 1'b0;
    @(negedge clk);
    n_run++;
    if (outs !== O_NONE) begin
      n_fail++;
      $display("FAIL dflush_cleared got %b expected %b", outs, O_NONE);
    end else $display("[TB] dflush_cleared ok %b", outs);
    tick();
    idle_inputs();
  endtask

  task automatic test_branch_lduse();
    set_lduse();
    branch_taken = 1'b1;
    @(negedge clk);
    n_run++;
    if (outs !== O_FLUSH) begin
      n_fail++;
      $display("FAIL br_lduse got %b expected %b", outs, O_FLUSH);
    end else $display("[TB] br_lduse ok %b", outs);
    tick();
    idle_inputs();
    @(negedge clk);
    n_run++;
    if (outs !== O_NONE) begin
      n_fail++;
      $display("FAIL br_after got %b expected %b", outs, O_NONE);
    end else $display("[TB] br_after ok %b", outs);
    tick();
  endtask

  task automatic test_reset_mid_wait();
    ex_mem_memop = 1'b1;
    dmem_rdy     = 1'b0;
    branch_taken = 1'b1;
    tick();
    branch_taken = 1'b0;
    rst_n        = 1'b0;
    tick();
    rst_n    = 1'b1;
    dmem_rdy = 1'b1;
    // the pending flush must have been discarded by the reset
    @(negedge clk);
    n_run++;
    if (outs !== O_NONE) begin
      n_fail++;
      $display("FAIL rst_midwait got %b expected %b", outs, O_NONE);
    end else $display("[TB] rst_midwait ok %b", outs);
    tick();
    idle_inputs();
  endtask

  task automatic test_halt();
    mem_wb_halt = 1'b1;
    tick();
    mem_wb_halt  = 1'b0;
    // hazards of every kind are present; HALT must still dominate
    ex_mem_memop = 1'b1;
    dmem_rdy     = 1'b0;
    branch_taken = 1'b1;
    set_lduse();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_run++;
      if (outs !== O_HALT) begin
        n_fail++;
        $display("FAIL halt_c%0d got %b expected %b", i, outs, O_HALT);
      end else $display("[TB] halt_c%0d ok %b", i, outs);
      tick();
    end
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    n_run++;
    if (outs !== O_NONE) begin
      n_fail++;
      $display("FAIL halt_rstlow got %b expected %b", outs, O_NONE);
    end else $display("[TB] halt_rstlow ok %b", outs);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    n_run++;
    if (outs !== O_NONE) begin
      n_fail++;
      $display("FAIL halt_left got %b expected %b", outs, O_NONE);
    end else $display("[TB] halt_left ok %b", outs);
    tick();
  endtask

`ifdef HAZ_PERF_EN
  task automatic test_perf();
    rst_n = 1'b0;
    idle_inputs();
    tick();
    rst_n = 1'b1;
    ex_mem_memop = 1'b1;
    dmem_rdy     = 1'b0;
    repeat (3) tick();
    dmem_rdy = 1'b1;
    tick();
    ex_mem_memop = 1'b0;
    branch_taken = 1'b1;
    tick();
    branch_taken = 1'b0;
    @(negedge clk);
    n_run++;
    if (perf_stall_cnt !== 16'd3) begin
      n_fail++;
      $display("FAIL perf_stall got %0d expected 3", perf_stall_cnt);
    end else $display("[TB] perf_stall ok %0d", perf_stall_cnt);
    n_run++;
    if (perf_flush_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL perf_flush got %0d expected 1", perf_flush_cnt);
    end else $display("[TB] perf_flush ok %0d", perf_flush_cnt);
    tick();
    ex_mem_memop = 1'b0;
    ex_mem_memop = 1'b1;
    dmem_rdy     = 1'b0;
    repeat (65540) tick();
    @(negedge clk);
    n_run++;
    if (perf_stall_cnt !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL perf_sat got %h expected ffff", perf_stall_cnt);
    end else $display("[TB] perf_sat ok %h", perf_stall_cnt);
    tick();
    idle_inputs();
  endtask
`endif

  initial begin
    test_reset();
    test_load_use();
    test_r0();
    test_memwait();
    test_deferred_flush();
    test_branch_lduse();
    test_reset_mid_wait();
    test_halt();
`ifdef HAZ_PERF_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
